// File: rtl/i2c_target_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target_rx_pkg
//  Description : Shared definitions for the I2C OLED command-path target:
//                FSM state encoding, control-byte bit positions, default
//                target address and an address-match helper.
//  Revision    : 1.0  initial release
// ============================================================================
package i2c_target_rx_pkg;

    // Receive-side protocol states; 3 bits covers all eight states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_CTRL     = 3'd3,
        ST_CTRL_ACK = 3'd4,
        ST_DATA     = 3'd5,
        ST_DATA_ACK = 3'd6,
        ST_IGNORE   = 3'd7
    } state_t;

    // SSD1306 control byte: Co (continuation) and D/C# bit positions.
    localparam int         c_co_bit       = 7;
    localparam int         c_dc_bit       = 6;
    localparam logic [6:0] c_default_addr = 7'h3C;

    // True when an address byte selects this target for a write.
    function automatic logic is_write_to(input logic [7:0] addr_byte,
                                         input logic [6:0] addr);
        return (addr_byte[7:1] == addr) && !addr_byte[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_target_rx_line_cond.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target_rx_line_cond
//  Description : SCL/SDA conditioning: per-line synchronizer (reset to bus
//                idle = 1), optional unanimity glitch filter, and strobes for
//                SCL rise/fall and START/STOP conditions.
//                Optional feature macro: I2C_GLITCH_FILTER_EN
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_target_rx_line_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    generate
        if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_bad_params
            $error("i2c_target_rx_line_cond: SYNC_STAGES must be >=2 and FILT_LEN >=1");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   w_scl_s;
    logic                   w_sda_s;
    logic                   w_scl_f;
    logic                   w_sda_f;
    logic                   r_scl_d;
    logic                   r_sda_d;

    // Metastability synchronizers; reset to 1 so a reset looks like an idle bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
        end
    end

    assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s = r_sda_sync[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILTER_EN
    logic [FILT_LEN-1:0] r_scl_hist;
    logic [FILT_LEN-1:0] r_sda_hist;
    logic                r_scl_filt;
    logic                r_sda_filt;

    // Filtered level only moves once FILT_LEN consecutive samples agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_hist <= '1;
            r_sda_hist <= '1;
            r_scl_filt <= 1'b1;
            r_sda_filt <= 1'b1;
        end else begin
            r_scl_hist <= FILT_LEN'({r_scl_hist, w_scl_s});
            r_sda_hist <= FILT_LEN'({r_sda_hist, w_sda_s});
            if (&r_scl_hist)       r_scl_filt <= 1'b1;
            else if (~|r_scl_hist) r_scl_filt <= 1'b0;
            if (&r_sda_hist)       r_sda_filt <= 1'b1;
            else if (~|r_sda_hist) r_sda_filt <= 1'b0;
        end
    end

    assign w_scl_f = r_scl_filt;
    assign w_sda_f = r_sda_filt;
`else
    assign w_scl_f = w_scl_s;
    assign w_sda_f = w_sda_s;
`endif

    // Previous conditioned levels for edge and bus-condition detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl_f;
            r_sda_d <= w_sda_f;
        end
    end

    // START/STOP require SCL high both before and after the SDA transition.
    assign o_sda      = w_sda_f;
    assign o_scl_rise = w_scl_f & ~r_scl_d;
    assign o_scl_fall = ~w_scl_f & r_scl_d;
    assign o_start    = w_scl_f & r_scl_d & r_sda_d & ~w_sda_f;
    assign o_stop     = w_scl_f & r_scl_d & ~r_sda_d & w_sda_f;

endmodule
`default_nettype wire

// File: rtl/i2c_target_rx.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target_rx
//  Description : Write-only I2C target for the OLED command path. Matches a
//                7-bit address, ACKs every byte, separates SSD1306 control
//                bytes from payload and pulses each command/data byte out.
//                Optional feature macro: I2C_GLITCH_FILTER_EN (line filter)
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_target_rx
    import i2c_target_rx_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = c_default_addr,
    parameter int          SYNC_STAGES = 2,
    parameter int          FILT_LEN    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_dc,
    output logic       frame_done,
    output logic       busy
);

    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_byte;

    state_t     r_state,      w_state_nx;
    logic [2:0] r_bit_cnt,    w_bit_cnt_nx;
    logic [6:0] r_shift,      w_shift_nx;
    logic       r_ack_ph,     w_ack_ph_nx;
    logic       r_co,         w_co_nx;
    logic       r_sda_oe,     w_sda_oe_nx;
    logic [7:0] r_rx_data,    w_rx_data_nx;
    logic       r_rx_valid,   w_rx_valid_nx;
    logic       r_rx_dc,      w_rx_dc_nx;
    logic       r_frame_done, w_frame_done_nx;
    logic       r_busy,       w_busy_nx;

    i2c_target_rx_line_cond #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_line_cond (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_scl      (scl_i),
        .i_sda      (sda_i),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    // Byte as it stands once the current SCL-rise bit is shifted in.
    assign w_byte = {r_shift, w_sda};

    // State register and all output registers; reset releases SDA at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 7'd0;
            r_ack_ph     <= 1'b0;
            r_co         <= 1'b0;
            r_sda_oe     <= 1'b0;
            r_rx_data    <= 8'd0;
            r_rx_valid   <= 1'b0;
            r_rx_dc      <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_bit_cnt    <= w_bit_cnt_nx;
            r_shift      <= w_shift_nx;
            r_ack_ph     <= w_ack_ph_nx;
            r_co         <= w_co_nx;
            r_sda_oe     <= w_sda_oe_nx;
            r_rx_data    <= w_rx_data_nx;
            r_rx_valid   <= w_rx_valid_nx;
            r_rx_dc      <= w_rx_dc_nx;
            r_frame_done <= w_frame_done_nx;
            r_busy       <= w_busy_nx;
        end
    end

    // Next-state logic; bus conditions take priority over SCL edges.
    always_comb begin
        w_state_nx      = r_state;
        w_bit_cnt_nx    = r_bit_cnt;
        w_shift_nx      = r_shift;
        w_ack_ph_nx     = r_ack_ph;
        w_co_nx         = r_co;
        w_sda_oe_nx     = r_sda_oe;
        w_rx_data_nx    = r_rx_data;
        w_rx_valid_nx   = 1'b0;
        w_rx_dc_nx      = r_rx_dc;
        w_frame_done_nx = 1'b0;
        w_busy_nx       = r_busy;

        if (w_stop) begin
            w_state_nx      = ST_IDLE;
            w_bit_cnt_nx    = 3'd0;
            w_ack_ph_nx     = 1'b0;
            w_sda_oe_nx     = 1'b0;
            w_frame_done_nx = r_busy;
            w_busy_nx       = 1'b0;
        end else if (w_start) begin
            w_state_nx   = ST_ADDR;
            w_bit_cnt_nx = 3'd0;
            w_ack_ph_nx  = 1'b0;
            w_sda_oe_nx  = 1'b0;
            w_busy_nx    = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR, ST_CTRL, ST_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nx   = w_byte[6:0];
                        w_bit_cnt_nx = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            case (r_state)
                                ST_ADDR: begin
                                    w_state_nx = is_write_to(w_byte, TARGET_ADDR)
                                               ? ST_ADDR_ACK : ST_IGNORE;
                                end
                                ST_CTRL: begin
                                    w_co_nx    = w_byte[c_co_bit];
                                    w_rx_dc_nx = w_byte[c_dc_bit];
                                    w_state_nx = ST_CTRL_ACK;
                                end
                                default: begin
                                    w_rx_data_nx  = w_byte;
                                    w_rx_valid_nx = 1'b1;
                                    w_state_nx    = ST_DATA_ACK;
                                end
                            endcase
                        end
                    end
                end
                ST_ADDR_ACK, ST_CTRL_ACK, ST_DATA_ACK: begin
                    // First SCL fall drives the ACK low, the second releases it.
                    if (w_scl_fall) begin
                        if (!r_ack_ph) begin
                            w_ack_ph_nx = 1'b1;
                            w_sda_oe_nx = 1'b1;
                            if (r_state == ST_ADDR_ACK) w_busy_nx = 1'b1;
                        end else begin
                            w_ack_ph_nx  = 1'b0;
                            w_sda_oe_nx  = 1'b0;
                            w_bit_cnt_nx = 3'd0;
                            case (r_state)
                                ST_ADDR_ACK: w_state_nx = ST_CTRL;
                                ST_CTRL_ACK: w_state_nx = ST_DATA;
                                default:     w_state_nx = r_co ? ST_CTRL : ST_DATA;
                            endcase
                        end
                    end
                end
                default: begin
                    // IDLE and IGNORE only leave on START/STOP.
                end
            endcase
        end
    end

    assign sda_oe     = r_sda_oe;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign rx_dc      = r_rx_dc;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;

endmodule
`default_nettype wire
